mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage (exec) and the writeback stage (wb). It accepts one operation at a time from exec and handles it by type:
- ALU results pass straight through.
- Loads and stores run over a request/grant/response data-memory port.
- Every completed operation goes into a single-entry output register that feeds wb over a valid/ready handshake.

A wait-cycle counter flags memory responses that never arrive.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_stage_if.sv | 53 +++++
 rtl/mem_stage_out_reg.sv | 57 +++++
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage.
// Op and FSM state encodings plus a small op helper.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    ALU   = 2'd1,
    LOAD  = 2'd2,
    STORE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_mem(op_e op);
    return (op == LOAD) || (op == STORE);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Exec, data-memory and writeback signals of the memory stage.
// slave is the stage itself, master is its surroundings.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);

  logic              ex_valid;
  logic              ex_ready;
  op_e               ex_op;
  logic [DATA_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic [RD_W-1:0]   ex_rd;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic              wb_ready;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;

  logic              err_timeout;

  modport slave (
    input  ex_valid, ex_op, ex_addr, ex_wdata, ex_rd,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  wb_ready,
    output ex_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_rd, wb_data, wb_we,
    output err_timeout
  );

  modport master (
    output ex_valid, ex_op, ex_addr, ex_wdata, ex_rd,
    output mem_gnt, mem_rvalid, mem_rdata,
    output wb_ready,
    input  ex_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_rd, wb_data, wb_we,
    input  err_timeout
  );

endinterface

// File: rtl/mem_stage_out_reg.sv
// Single-entry valid/ready register carrying {rd, data, we}.
// Loads and drains in the same cycle for full throughput.
module mem_stage_out_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [RD_W-1:0]   in_rd_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_we_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [RD_W-1:0]   out_rd_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_we_o
);

  logic              valid_q, valid_d;
  logic [RD_W-1:0]   rd_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;
  logic              load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  always_comb begin
    valid_d = valid_q;
    if (load)             valid_d = 1'b1;
    else if (out_ready_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        rd_q   <= in_rd_i;
        data_q <= in_data_i;
        we_q   <= in_we_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_rd_o    = rd_q;
  assign out_data_o  = data_q;
  assign out_we_o    = we_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: ALU pass-through, one load/store in flight,
// single-entry result register towards writeback, load timeout flag.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic              ov_valid, ov_ready, ov_we;
  logic [RD_W-1:0]   ov_rd;
  logic [DATA_W-1:0] ov_data;
  logic              ex_rdy;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    data_d   = data_q;
    we_d     = we_q;
    err_d    = err_q;
    ov_valid = 1'b0;
    ov_rd    = bus.ex_rd;
    ov_data  = '0;
    ov_we    = 1'b0;
    ex_rdy   = 1'b0;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        ex_rdy = ov_ready;
        if (bus.ex_valid && ov_ready) begin
          unique case (1'b1)
            is_mem(bus.ex_op): begin
              op_d    = bus.ex_op;
              addr_d  = bus.ex_addr;
              wdata_d = bus.ex_wdata;
              rd_d    = bus.ex_rd;
              state_d = REQ;
            end
            default: begin
              ov_valid = 1'b1;
              ov_we    = (bus.ex_op == ALU);
              ov_data  = ov_we ? bus.ex_addr : '0;
            end
          endcase
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          if (op_q == STORE) begin
            data_d  = '0;
            we_d    = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A response in the deadline cycle still counts as on time.
        if (bus.mem_rvalid) begin
          data_d  = bus.mem_rdata;
          we_d    = 1'b1;
          state_d = DONE;
        end else if (cnt_inc == CNT_MAX) begin
          err_d   = 1'b1;
          data_d  = '0;
          we_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        ov_valid = 1'b1;
        ov_rd    = rd_q;
        ov_data  = data_q;
        ov_we    = we_q;
        if (ov_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= NOP;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  mem_stage_out_reg #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (ov_valid),
    .in_ready_o  (ov_ready),
    .in_rd_i     (ov_rd),
    .in_data_i   (ov_data),
    .in_we_i     (ov_we),
    .out_valid_o (bus.wb_valid),
    .out_ready_i (bus.wb_ready),
    .out_rd_o    (bus.wb_rd),
    .out_data_o  (bus.wb_data),
    .out_we_o    (bus.wb_we)
  );

  assign bus.ex_ready    = ex_rdy;
  assign bus.mem_req     = (state_q == REQ);
  assign bus.mem_we      = (state_q == REQ) && (op_q == STORE);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scenario bench for mem_stage: inputs driven on the falling edge,
// writeback results checked against a queue of expected entries.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t e;

  mem_stage_if #(.DATA_W(32), .RD_W(5)) bus ();

  mem_stage #(
    .DATA_W  (32),
    .RD_W    (5),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle_in();
    bus.ex_valid   = 1'b0;
    bus.ex_op      = NOP;
    bus.ex_addr    = '0;
    bus.ex_wdata   = '0;
    bus.ex_rd      = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d,
                      input logic we);
    exp_t x;
    x.rd = rd; x.data = d; x.we = we;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    idle_in();
    bus.wb_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.ex_ready, bus.mem_req, bus.mem_we, bus.wb_valid,
         bus.wb_we, bus.err_timeout} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 100000",
        {bus.ex_ready, bus.mem_req, bus.mem_we, bus.wb_valid,
         bus.wb_we, bus.err_timeout});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.wb_data, bus.wb_rd} !== '0) begin
      bad++;
      $display("FAIL reset_data: addr=%h wdata=%h data=%h rd=%0d want 0",
        bus.mem_addr, bus.mem_wdata, bus.wb_data, bus.wb_rd);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_b2b();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle_in();
      bus.wb_ready = 1'b1;
      bus.ex_valid = (i < 4);
      bus.ex_op    = ALU;
      bus.ex_addr  = 32'(i + 1);
      bus.ex_rd    = 5'(i + 1);
      #1;
      if (i < 4) begin
        total++;
        if (bus.ex_ready !== 1'b1) begin
          bad++;
          $display("FAIL alu_ready[%0d]: got %b want 1", i, bus.ex_ready);
        end
      end
      total++;
      if (bus.wb_valid !== (i >= 1 && i <= 4)) begin
        bad++;
        $display("FAIL alu_valid[%0d]: got %b want %b", i, bus.wb_valid,
          (i >= 1 && i <= 4));
      end
      if (bus.wb_valid && bus.wb_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL alu_sb: unexpected output rd=%0d", bus.wb_rd);
        end else begin
          e = sb.pop_front();
          if ({bus.wb_rd, bus.wb_data, bus.wb_we} !== e) begin
            bad++;
            $display("FAIL alu_out: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
              bus.wb_rd, bus.wb_data, bus.wb_we, e.rd, e.data, e.we);
          end
        end
      end
      if (bus.ex_valid && bus.ex_ready) push(5'(i + 1), 32'(i + 1), 1'b1);
    end
  endtask

  task automatic test_load();
    int nreq = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle_in();
      bus.ex_valid   = (k == 0);
      bus.ex_op      = LOAD;
      bus.ex_addr    = 32'h100;
      bus.ex_rd      = 5'd7;
      bus.mem_gnt    = (k == 4);
      bus.mem_rvalid = (k == 6);
      bus.mem_rdata  = (k == 6) ? 32'hDEADBEEF : 32'h0;
      #1;
      if (k <= 8) begin
        total++;
        if (bus.ex_ready !== (k == 0 || k == 8)) begin
          bad++;
          $display("FAIL load_ready[%0d]: got %b want %b", k, bus.ex_ready,
            (k == 0 || k == 8));
        end
      end
      if (bus.mem_req) nreq++;
      if (k >= 1 && k <= 4) begin
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h100}) begin
          bad++;
          $display("FAIL load_req[%0d]: got req=%b we=%b addr=%h want 1 0 100",
            k, bus.mem_req, bus.mem_we, bus.mem_addr);
        end
      end
      total++;
      if (bus.wb_valid !== (k == 8)) begin
        bad++;
        $display("FAIL load_valid[%0d]: got %b want %b", k, bus.wb_valid,
          (k == 8));
      end
      if (bus.wb_valid && bus.wb_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL load_sb: unexpected output rd=%0d", bus.wb_rd);
        end else begin
          e = sb.pop_front();
          if ({bus.wb_rd, bus.wb_data, bus.wb_we} !== e) begin
            bad++;
            $display("FAIL load_out: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
              bus.wb_rd, bus.wb_data, bus.wb_we, e.rd, e.data, e.we);
          end
        end
      end
      if (k == 0 && bus.ex_ready) push(5'd7, 32'hDEADBEEF, 1'b1);
    end
    total++;
    if (nreq != 4) begin
      bad++;
      $display("FAIL load_req_cycles: got %0d want 4", nreq);
    end
  endtask

  task automatic test_store();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_in();
      bus.ex_valid = (k == 0);
      bus.ex_op    = STORE;
      bus.ex_addr  = 32'h40;
      bus.ex_wdata = 32'h55;
      bus.ex_rd    = 5'd3;
      bus.mem_gnt  = (k == 1);
      #1;
      total++;
      if ({bus.mem_req, bus.mem_we} !== {2{k == 1}}) begin
        bad++;
        $display("FAIL store_req[%0d]: got req=%b we=%b want %b", k,
          bus.mem_req, bus.mem_we, (k == 1));
      end
      if (k == 1) begin
        total++;
        if ({bus.mem_addr, bus.mem_wdata} !== {32'h40, 32'h55}) begin
          bad++;
          $display("FAIL store_bus: got addr=%h wdata=%h want 40 55",
            bus.mem_addr, bus.mem_wdata);
        end
      end
      total++;
      if (bus.wb_valid !== (k == 3)) begin
        bad++;
        $display("FAIL store_valid[%0d]: got %b want %b", k, bus.wb_valid,
          (k == 3));
      end
      if (bus.wb_valid && bus.wb_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL store_sb: unexpected output rd=%0d", bus.wb_rd);
        end else begin
          e = sb.pop_front();
          if ({bus.wb_rd, bus.wb_data, bus.wb_we} !== e) begin
            bad++;
            $display("FAIL store_out: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
              bus.wb_rd, bus.wb_data, bus.wb_we, e.rd, e.data, e.we);
          end
        end
      end
      if (k == 0 && bus.ex_ready) push(5'd3, 32'h0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      idle_in();
      bus.wb_ready = (k >= 3);
      bus.ex_valid = (k <= 3);
      bus.ex_op    = ALU;
      bus.ex_addr  = (k == 0) ? 32'hA5 : 32'hB6;
      bus.ex_rd    = (k == 0) ? 5'd5 : 5'd6;
      #1;
      if (k <= 3) begin
        total++;
        if (bus.ex_ready !== (k == 0 || k == 3)) begin
          bad++;
          $display("FAIL bp_ready[%0d]: got %b want %b", k, bus.ex_ready,
            (k == 0 || k == 3));
        end
      end
      if (k == 1 || k == 2) begin
        total++;
        if ({bus.wb_valid, bus.wb_rd, bus.wb_data} !== {1'b1, 5'd5, 32'hA5}) begin
          bad++;
          $display("FAIL bp_hold[%0d]: got v=%b rd=%0d data=%h want 1 5 a5",
            k, bus.wb_valid, bus.wb_rd, bus.wb_data);
        end
      end
      total++;
      if (bus.wb_valid !== (k >= 1 && k <= 4)) begin
        bad++;
        $display("FAIL bp_valid[%0d]: got %b want %b", k, bus.wb_valid,
          (k >= 1 && k <= 4));
      end
      if (bus.wb_valid && bus.wb_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL bp_sb: unexpected output rd=%0d", bus.wb_rd);
        end else begin
          e = sb.pop_front();
          if ({bus.wb_rd, bus.wb_data, bus.wb_we} !== e) begin
            bad++;
            $display("FAIL bp_out: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
              bus.wb_rd, bus.wb_data, bus.wb_we, e.rd, e.data, e.we);
          end
        end
      end
      if (bus.ex_valid && bus.ex_ready) push(bus.ex_rd, bus.ex_addr, 1'b1);
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle_in();
      bus.wb_ready = 1'b1;
      bus.ex_valid = (k == 0 || k == 8);
      bus.ex_op    = (k == 0) ? LOAD : ALU;
      bus.ex_addr  = (k == 0) ? 32'h200 : 32'h77;
      bus.ex_rd    = (k == 0) ? 5'd9 : 5'd2;
      bus.mem_gnt  = (k == 1);
      #1;
      total++;
      if (bus.err_timeout !== (k >= 6)) begin
        bad++;
        $display("FAIL to_err[%0d]: got %b want %b", k, bus.err_timeout,
          (k >= 6));
      end
      if (k <= 8) begin
        total++;
        if (bus.ex_ready !== (k == 0 || k >= 7)) begin
          bad++;
          $display("FAIL to_ready[%0d]: got %b want %b", k, bus.ex_ready,
            (k == 0 || k >= 7));
        end
      end
      total++;
      if ({bus.mem_req, bus.wb_valid} !== {k == 1, k == 7 || k == 9}) begin
        bad++;
        $display("FAIL to_ctl[%0d]: got req=%b valid=%b want %b %b", k,
          bus.mem_req, bus.wb_valid, (k == 1), (k == 7 || k == 9));
      end
      if (bus.wb_valid && bus.wb_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL to_sb: unexpected output rd=%0d", bus.wb_rd);
        end else begin
          e = sb.pop_front();
          if ({bus.wb_rd, bus.wb_data, bus.wb_we} !== e) begin
            bad++;
            $display("FAIL to_out: got rd=%0d data=%h we=%b want rd=%0d data=%h we=%b",
              bus.wb_rd, bus.wb_data, bus.wb_we, e.rd, e.data, e.we);
          end
        end
      end
      if (bus.ex_valid && bus.ex_ready) begin
        if (k == 0) push(5'd9, 32'h0, 1'b0);
        else        push(5'd2, 32'h77, 1'b1);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      idle_in();
      bus.wb_ready   = 1'b1;
      bus.ex_valid   = (k == 0);
      bus.ex_op      = LOAD;
      bus.ex_addr    = 32'h300;
      bus.ex_rd      = 5'd4;
      bus.mem_gnt    = (k == 1);
      bus.mem_rvalid = (k == 3);
      bus.mem_rdata  = 32'h1234;
      rst            = (k == 2);
      #1;
      if (k == 2) begin
        total++;
        if ({bus.err_timeout, bus.mem_req, bus.ex_ready} !== 3'b100) begin
          bad++;
          $display("FAIL rw_wait: got err=%b req=%b rdy=%b want 1 0 0",
            bus.err_timeout, bus.mem_req, bus.ex_ready);
        end
      end
      if (k >= 3) begin
        total++;
        if ({bus.ex_ready, bus.mem_req, bus.wb_valid, bus.err_timeout}
            !== 4'b1000) begin
          bad++;
          $display("FAIL rw_after[%0d]: got rdy=%b req=%b v=%b err=%b want 1 0 0 0",
            k, bus.ex_ready, bus.mem_req, bus.wb_valid, bus.err_timeout);
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu_b2b();
    test_load();
    test_store();
    test_backpressure();
    test_timeout();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
